// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: word width, FSM state
// encoding and the slice-count derivation.
package sub_pkg;

   localparam int WORD_W = 64;

   // Wide enough to count up to 64 slices (SLICE_W = 1) without wrapping.
   localparam int CNT_W = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of cycles needed to walk the whole word; slice_w must divide 64.
   function automatic int slice_count(input int slice_w);
      return WORD_W / slice_w;
   endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit borrow-ripple subtractor: d = x - y - bin,
// bout is the borrow out of the top bit.
module sub_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] br;

   // Ripple the borrow from bit 0 upward, one full-subtractor per bit.
   always_comb begin
      br    = '0;
      d     = '0;
      br[0] = bin;
      for (int i = 0; i < W; i++) begin
         d[i]    = x[i] ^ y[i] ^ br[i];
         br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
      end
      bout = br[W];
   end

endmodule

// File: rtl/serial_subtractor.sv
// Serial 64-bit unsigned subtractor processing SLICE_W bits per cycle.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE, out_valid only in DONE, so an input
// accept and an output hand-off never share a cycle.
// Optional macro SERIAL_SUBTRACTOR_FLAGS_EN adds registered zero/ovf outputs.
// fsm_state exposes the current FSM state for observation.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int SLICE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       a,
   input  logic [63:0]       b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [64:0]       diff,
   output logic [1:0]        fsm_state
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   ,
   output logic              zero,
   output logic              ovf
`endif
);

   localparam int SLICES = slice_count(SLICE_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

   state_t state;
   state_t state_nxt;

   logic [WORD_W-1:0] a_q;
   logic [WORD_W-1:0] b_q;
   logic [WORD_W:0]   diff_q;
   logic              borrow;
   logic [CNT_W-1:0]  cnt;

   logic [SLICE_W-1:0] x_s;
   logic [SLICE_W-1:0] y_s;
   logic [SLICE_W-1:0] d_s;
   logic               bout_s;

   logic accept;
   logic last;

   assign x_s       = a_q[cnt*SLICE_W +: SLICE_W];
   assign y_s       = b_q[cnt*SLICE_W +: SLICE_W];
   assign diff      = diff_q;
   assign fsm_state = state;

   sub_slice #(.W(SLICE_W)) u_slice (
      .x    (x_s),
      .y    (y_s),
      .bin  (borrow),
      .d    (d_s),
      .bout (bout_s)
   );

   // State register; reset overrides any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = (cnt == LAST);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture and one slice of subtraction per RUN cycle. Unwritten
   // diff bits keep their previous contents until their slice comes round.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (state == RUN) begin
         diff_q[cnt*SLICE_W +: SLICE_W] <= d_s;
         borrow <= bout_s;
         cnt    <= cnt + 1'b1;
         if (last) diff_q[WORD_W] <= bout_s;
      end
   end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   logic run_zero;

   // Accumulate an all-zero indication per slice; publish both flags on the
   // edge that writes the final slice so they line up with out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_zero <= 1'b0;
         zero     <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         run_zero <= 1'b1;
      end else if (state == RUN) begin
         run_zero <= run_zero & (d_s == '0);
         if (last) begin
            zero <= run_zero & (d_s == '0);
            ovf  <= (a_q[WORD_W-1] ^ b_q[WORD_W-1]) &
                    (d_s[SLICE_W-1] ^ a_q[WORD_W-1]);
         end
      end
   end
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: SLICE_W, 8, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands a/b valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  64  minuend, unsigned.
REQ-007 b  input  64  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff holds a completed result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 diff  output  65  [63:0] = (a - b) mod 2^64; [64] = final borrow (1 when a < b).

Function
REQ-011 Three states: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 IDLE: in_valid&in_ready latches a, b, borrow=0, slice counter=0 -> RUN; otherwise stay in IDLE.
REQ-013 RUN: each cycle computes slice k = a[k] - b[k] - borrow, writes diff[k*SLICE_W +: SLICE_W], updates borrow, increments k.
REQ-014 RUN -> DONE on the edge that processes slice 64/SLICE_W-1; same edge writes diff[64]=final borrow.
REQ-015 Latency: out_valid rises exactly 64/SLICE_W cycles after the accepting edge (8 cycles at default).
REQ-016 DONE: diff and out_valid held stable while out_ready=0; out_valid&out_ready -> IDLE.
REQ-017 Operands captured only at acceptance; a/b changes during RUN/DONE have no effect.
REQ-018 No input/output overlap: a new accept occurs no earlier than the cycle after result hand-off (one-cycle IDLE bubble).
REQ-019 diff bits not yet written in RUN retain prior values; diff is valid only while out_valid=1.
REQ-020 in_valid held in RUN/DONE is neither consumed nor dropped; it is accepted once IDLE is reached.

Reset
REQ-021 rst=1 at an edge: state=IDLE, diff=0, borrow=0, counter=0, out_valid=0, in_ready=1 from the next cycle.
REQ-022 Reset during RUN or DONE abandons the operation; no partial result is ever presented.
REQ-023 rst has priority over every handshake in the same cycle.

Configuration
REQ-024 Macro SERIAL_SUBTRACTOR_FLAGS_EN defined: adds outputs zero (1 bit, diff[63:0]==0) and ovf (1 bit, signed two's-complement overflow of a-b), both registered, valid with out_valid, reset to 0.
REQ-025 Macro undefined: zero and ovf ports and their logic are absent; all other behaviour is identical.

Structure
REQ-026 Shared package sub_pkg holds WORD_W=64, the state enum (IDLE/RUN/DONE), and the slice count derivation.
REQ-027 One sub-module, sub_slice: combinational SLICE_W-bit borrow-ripple subtractor (x, y, bin -> d, bout), instanced once.

Verification
REQ-028 a=10, b=3, SLICE_W=8 -> out_valid 8 cycles after accept, diff=65'h0_0000_0000_0000_0007.
REQ-029 a=0, b=1 -> diff[63:0]=64'hFFFF_FFFF_FFFF_FFFF, diff[64]=1.
REQ-030 a=64'h0000_0001_0000_0000, b=1 -> diff=65'h0_0000_0000_FFFF_FFFF; borrow crosses four slices.
REQ-031 out_ready=0 for 5 cycles in DONE with in_valid=1 -> diff stable, in_ready=0; after hand-off, next operand accepted one cycle later.
REQ-032 rst pulsed in 3rd RUN cycle -> next cycle out_valid=0, in_ready=1, diff=0; a subsequent 7-2 yields 5.
REQ-033 With SERIAL_SUBTRACTOR_FLAGS_EN: 64'h8000_0000_0000_0000 - 1 -> ovf=1, zero=0; 5-5 -> zero=1, ovf=0, diff[64]=0.
